// File: rtl/pipe_pkg.sv
// Shared constants and stage encoding for the pipeline occupancy tracker.
package pipe_pkg;

  localparam int STAGE_W   = 3;
  localparam int MAX_DEPTH = 7;

  typedef enum logic [STAGE_W-1:0] {
    IF  = 3'd0,
    ID  = 3'd1,
    EX  = 3'd2,
    MEM = 3'd3,
    WB  = 3'd4,
    NOP = 3'b111
  } stage_code_e;

endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline stage: valid bit plus instruction tag, with load/hold/kill.
module pipe_stage_reg #(
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             kill,
  input  logic             next_valid,
  input  logic [TAG_W-1:0] next_tag,
  output logic             valid,
  output logic [TAG_W-1:0] tag
);

  // Kill clears only the valid bit so a bubble keeps its stale tag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid <= 1'b0;
      tag   <= '0;
    end else if (kill) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= next_valid;
      tag   <= next_tag;
    end
  end

endmodule

// File: rtl/pipeline_tracker.sv
// In-order N-stage pipeline occupancy/state tracker with issue, stall and flush.
// Optional perf counters are built when PIPE_PERF_CNT_EN is defined.
module pipeline_tracker
  import pipe_pkg::*;
#(
  parameter int DEPTH        = 5,
  parameter int TAG_W        = 8,
  parameter int HOLD_STAGE   = 1,
  parameter int FLUSH_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          stall,
  input  logic                          flush,
  input  logic                          issue_valid,
  output logic                          issue_ready,
  output logic [DEPTH-1:0]              stage_valid,
  output logic [DEPTH*TAG_W-1:0]        tag_flat,
  output logic [STAGE_W*DEPTH-1:0]      state_flat,
  output logic                          retire_valid,
  output logic [TAG_W-1:0]              retire_tag,
  output logic [$clog2(DEPTH+1)-1:0]    occupancy,
  output logic [31:0]                   perf_retired,
  output logic [31:0]                   perf_bubbles,
  output logic [31:0]                   perf_flushed
);

  localparam int OCC_W = $clog2(DEPTH+1);

  logic [TAG_W-1:0] tag_cnt;
  logic [TAG_W-1:0] stage_tag [DEPTH];
  logic [DEPTH-1:0] load;
  logic [DEPTH-1:0] kill;
  logic             issue_accept;

  assign issue_ready  = en & ~stall & ~flush;
  assign issue_accept = issue_valid & issue_ready;
  assign retire_valid = en & stage_valid[DEPTH-1];
  assign retire_tag   = stage_tag[DEPTH-1];

  // Per-stage control; flush outranks stall, and en=0 leaves every stage holding.
  always_comb begin
    load = '0;
    kill = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (en) begin
        if (flush) begin
          if (i < FLUSH_STAGES) kill[i] = 1'b1;
          else                  load[i] = 1'b1;
        end else if (stall) begin
          if (i == HOLD_STAGE + 1)    kill[i] = 1'b1;
          else if (i > HOLD_STAGE + 1) load[i] = 1'b1;
        end else begin
          load[i] = 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    logic             nv;
    logic [TAG_W-1:0] nt;
    if (g == 0) begin : g_head
      assign nv = issue_valid;
      assign nt = tag_cnt;
    end else begin : g_body
      assign nv = stage_valid[g-1];
      assign nt = stage_tag[g-1];
    end

    pipe_stage_reg #(.TAG_W(TAG_W)) u_reg (
      .clk        (clk),
      .rst        (rst),
      .load       (load[g]),
      .kill       (kill[g]),
      .next_valid (nv),
      .next_tag   (nt),
      .valid      (stage_valid[g]),
      .tag        (stage_tag[g])
    );

    assign tag_flat[g*TAG_W +: TAG_W]       = stage_tag[g];
    assign state_flat[g*STAGE_W +: STAGE_W] = stage_valid[g] ? STAGE_W'(g) : NOP;
  end

  always_ff @(posedge clk) begin
    if (!rst)              tag_cnt <= '0;
    else if (issue_accept) tag_cnt <= tag_cnt + TAG_W'(1);
  end

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < DEPTH; i++) occupancy = occupancy + OCC_W'(stage_valid[i]);
  end

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] killed_cnt;

  always_comb begin
    killed_cnt = '0;
    for (int i = 0; i < FLUSH_STAGES; i++) killed_cnt = killed_cnt + 32'(stage_valid[i]);
  end

  // Counters only move on enabled cycles; a bubble counts only if stage HOLD_STAGE held real work.
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_retired <= '0;
      perf_bubbles <= '0;
      perf_flushed <= '0;
    end else if (en) begin
      if (stage_valid[DEPTH-1])                    perf_retired <= perf_retired + 32'd1;
      if (stall && !flush && stage_valid[HOLD_STAGE]) perf_bubbles <= perf_bubbles + 32'd1;
      if (flush)                                   perf_flushed <= perf_flushed + killed_cnt;
    end
  end
`else
  assign perf_retired = '0;
  assign perf_bubbles = '0;
  assign perf_flushed = '0;
`endif

endmodule

// File: tb/tb_pipeline_tracker.sv
// Directed self-checking bench for pipeline_tracker with default parameters.
module tb_pipeline_tracker;

  logic        clk = 1'b0;
  logic        rst, en, stall, flush, issue_valid;
  logic        issue_ready, retire_valid;
  logic [4:0]  stage_valid;
  logic [39:0] tag_flat;
  logic [14:0] state_flat;
  logic [7:0]  retire_tag;
  logic [2:0]  occupancy;
  logic [31:0] perf_retired, perf_bubbles, perf_flushed;

  int testCount = 0;
  int failCount = 0;

`ifdef PIPE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  pipeline_tracker dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .stall        (stall),
    .flush        (flush),
    .issue_valid  (issue_valid),
    .issue_ready  (issue_ready),
    .stage_valid  (stage_valid),
    .tag_flat     (tag_flat),
    .state_flat   (state_flat),
    .retire_valid (retire_valid),
    .retire_tag   (retire_tag),
    .occupancy    (occupancy),
    .perf_retired (perf_retired),
    .perf_bubbles (perf_bubbles),
    .perf_flushed (perf_flushed)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic r, input logic e, input logic s,
                               input logic f, input logic iv);
    rst = r; en = e; stall = s; flush = f; issue_valid = iv;
    #1;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    testCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    end
  endtask

  initial begin
    // reset with en=0
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    advance();
    checkOutput("rst_state", 64'(state_flat), 64'h7FFF);
    checkOutput("rst_occ", 64'(occupancy), 64'd0);
    checkOutput("rst_retire", 64'(retire_valid), 64'd0);
    checkOutput("rst_ready_en0", 64'(issue_ready), 64'd0);

    // back-to-back issues, edges 1..7
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("ready_normal", 64'(issue_ready), 64'd1);
    for (int n = 1; n <= 7; n++) begin
      advance();
      checkOutput("issue_tag_s0", 64'(tag_flat[7:0]), 64'(n - 1));
      if (n == 4) checkOutput("retire_early", 64'(retire_valid), 64'd0);
      if (n == 5) begin
        checkOutput("retire_first", 64'(retire_valid), 64'd1);
        checkOutput("retire_tag0", 64'(retire_tag), 64'd0);
        checkOutput("occ_full", 64'(occupancy), 64'd5);
      end
    end
    checkOutput("full_tags", 64'(tag_flat), 64'h0203040506);

    // two stall cycles
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("ready_stall", 64'(issue_ready), 64'd0);
    advance();
    checkOutput("stall1_state", 64'(state_flat), 64'h47C8);
    advance();
    checkOutput("stall2_state", 64'(state_flat), 64'h4FC8);
    checkOutput("stall2_hold_tags", 64'(tag_flat[15:0]), 64'h0506);
    checkOutput("stall2_valid", 64'(stage_valid), 64'b10011);
    checkOutput("perf_bubbles", 64'(perf_bubbles), PERF ? 64'd2 : 64'd0);

    // flush together with stall
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("ready_flush", 64'(issue_ready), 64'd0);
    advance();
    checkOutput("flush_valid", 64'(stage_valid), 64'b00100);
    checkOutput("flush_s2_tag", 64'(tag_flat[23:16]), 64'd5);
    checkOutput("flush_occ", 64'(occupancy), 64'd1);
    checkOutput("perf_flushed", 64'(perf_flushed), PERF ? 64'd2 : 64'd0);
    checkOutput("perf_bubbles_flush", 64'(perf_bubbles), PERF ? 64'd2 : 64'd0);

    // refill: dropped issue means the next tag is 7
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    advance();
    checkOutput("refill_tag7", 64'(tag_flat[7:0]), 64'd7);
    for (int n = 0; n < 4; n++) advance();
    checkOutput("refill_tags", 64'(tag_flat), 64'h0708090A0B);
    checkOutput("perf_retired", 64'(perf_retired), PERF ? 64'd6 : 64'd0);

    // en=0 freeze for 3 cycles while other inputs toggle
    for (int n = 0; n < 3; n++) begin
      applyStimulus(1'b1, 1'b0, n[0], n[1], 1'b1);
      checkOutput("frz_retire", 64'(retire_valid), 64'd0);
      checkOutput("frz_ready", 64'(issue_ready), 64'd0);
      advance();
      checkOutput("frz_tags", 64'(tag_flat), 64'h0708090A0B);
      checkOutput("frz_valid", 64'(stage_valid), 64'b11111);
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    advance();
    checkOutput("post_frz_tag", 64'(tag_flat[7:0]), 64'd12);
    checkOutput("post_frz_retire", 64'(retire_tag), 64'd8);

    // reset mid-stream with en=0
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    advance();
    checkOutput("mid_rst_state", 64'(state_flat), 64'h7FFF);
    checkOutput("mid_rst_occ", 64'(occupancy), 64'd0);
    checkOutput("mid_rst_perf", 64'({perf_retired, perf_bubbles} | 64'(perf_flushed)), 64'd0);

    // 257 accepted issues: tag counter wraps
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int n = 1; n <= 257; n++) begin
      advance();
      if (n == 1)   checkOutput("wrap_first", 64'(tag_flat[7:0]), 64'd0);
      if (n == 256) checkOutput("wrap_last", 64'(tag_flat[7:0]), 64'd255);
      if (n == 257) checkOutput("wrap_257", 64'(tag_flat[7:0]), 64'd0);
    end
    checkOutput("wrap_retire_tag", 64'(retire_tag), 64'd252);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
